uart_cmd_pkt: RTL and testbench
===============================

// Module: uart_cmd_pkt
// PURPOSE
//  Parametrised command-packet framer between the 8-bit UART byte interface and the flight controller.
//  RX side: assembles {cmd, DATA_BYTES payload MSB-first, optional checksum}, with inter-byte timeout resync.
//  TX side: response bytes are queued in a RESP_DEPTH FIFO and drained to the UART transmitter one at a time.
//  Replaces fixed 3-byte framing; UART core instantiated by the parent, not here.
// PARAMETERS
//  DATA_BYTES    2     payload bytes after cmd (>=1); data width = 8*DATA_BYTES
//  CHK_EN        0     1: one trailing checksum byte expected and verified
//  TIMEOUT_CLKS  50000 max clks between bytes of one packet; 0 disables timeout
//  RESP_DEPTH    4     response FIFO depth, power of 2, >=2
// PORTS
//  clk          in   1              system clock, all logic on posedge
//  rst          in   1              async active-high reset
//  rx_data      in   8              byte from UART receiver
//  rx_rdy       in   1              UART byte valid (level until cleared)
//  clr_rx_rdy   out  1              comb; high in the cycle a byte is consumed
//  cmd_rdy      out  1              complete valid packet held on cmd/data
//  cmd          out  8              opcode of last accepted packet
//  data         out  8*DATA_BYTES   payload of last accepted packet, first byte in MSBs
//  clr_cmd_rdy  in   1              host consumed packet
//  chk_err      out  1              1-clk pulse: packet dropped, bad checksum
//  pkt_timeout  out  1              1-clk pulse: partial packet dropped, timeout
//  resp         in   8              response byte to queue
//  send_resp    in   1              push resp into FIFO (1 clk)
//  resp_full    out  1              FIFO full
//  resp_ovf     out  1              1-clk pulse: push dropped (full, no pop)
//  tx_data      out  8              FIFO head to UART transmitter
//  trmt         out  1              1-clk start pulse to UART transmitter
//  tx_done      in   1              UART transmitter finished byte
//  resp_sent    out  1              registered 1-clk pulse, one per byte popped
// BEHAVIOUR
//  Reset: cmd_rdy,cmd,data,chk_err,pkt_timeout,resp_ovf,trmt,resp_sent=0; FIFO empty; both FSMs idle. Async, any time.
//  RX FSM states: IDLE, PAYLOAD, CHK. Byte consumed only when rx_rdy=1; clr_rx_rdy=1 same cycle.
//   IDLE: byte -> shadow cmd, chk_sum<=byte, byte_cnt<=0, cmd_rdy<=0, -> PAYLOAD.
//   PAYLOAD: byte -> shadow payload shifted left 8, chk_sum+=byte; on byte_cnt==DATA_BYTES-1:
//    CHK_EN=0: cmd/data<=shadow (incl. this byte), cmd_rdy<=1, -> IDLE; CHK_EN=1: -> CHK.
//   CHK: ok iff (chk_sum+byte) mod 256 == 0: copy shadow to cmd/data, cmd_rdy<=1; else chk_err pulse; -> IDLE.
//  cmd/data change only on acceptance; hold last good packet through errors/timeouts.
//  Latency: cmd_rdy high the clk after the final byte is consumed.
//  cmd_rdy: set by accept, cleared by clr_cmd_rdy or first byte of next packet; accept same clk as clr_cmd_rdy -> set wins.
//  Timeout: counter 0 on every consumed byte and in IDLE; counts in PAYLOAD/CHK without rx_rdy;
//   at TIMEOUT_CLKS -> pkt_timeout pulse, shadow discarded, -> IDLE. rx_rdy same clk as expiry: byte wins, no timeout.
//  FIFO: push on send_resp if not full; full & no pop -> drop, resp_ovf pulse; push+pop same clk when full -> both, count kept.
//  TX FSM states: TX_IDLE, TX_WAIT. TX_IDLE & !empty: trmt=1 one clk, tx_data=head, -> TX_WAIT.
//   TX_WAIT: tx_data held; on tx_done pop head, resp_sent pulse next clk, -> TX_IDLE. >=1 idle clk between trmts.
//  Pointers wrap mod RESP_DEPTH with extra MSB for full/empty. RX and TX paths fully independent.
// TESTING
//  DATA_BYTES=2,CHK_EN=0: bytes 0x05,0x12,0x34 -> cmd=0x05,data=0x1234,cmd_rdy=1; clr_cmd_rdy -> 0; 3 clr_rx_rdy pulses.
//  CHK_EN=1: 0x02,0x10,0x20,0xCE -> accept data=0x1020; repeat with 0xCF -> chk_err pulse, cmd/data unchanged, no cmd_rdy.
//  TIMEOUT_CLKS=100: 0x05,0xAA then 101 idle clks -> pkt_timeout; then 0x07,0x00,0x01 -> cmd=0x07,data=0x0001.
//  cmd_rdy=1, new byte 0x09 -> cmd_rdy 0 next clk; final byte coincident with clr_cmd_rdy -> cmd_rdy=1.
//  Push 0xA1..0xA5 back-to-back, tx_done 10 clks after each trmt -> 4 bytes sent in order, 0xA5 drops w/ resp_ovf.
//  rst asserted mid-packet and mid-TX -> all outputs 0, FIFO empty; next full packet accepted normally.

Source files
------------

// File: rtl/uart_cmd_pkt.sv
// uart_cmd_pkt
//   Command-packet framer between an 8-bit UART byte interface and the flight
//   controller.
//   RX: assembles {cmd, DATA_BYTES payload bytes MSB-first, optional checksum}.
//       A partial packet is dropped if the gap between its bytes exceeds
//       TIMEOUT_CLKS clocks.
//   TX: response bytes are queued in a RESP_DEPTH FIFO and handed to the UART
//       transmitter one at a time.
// Ports
//   clk, rst                   clock, async active-high reset
//   rx_data, rx_rdy            byte from UART receiver, level-valid
//   clr_rx_rdy                 comb, high in the cycle a byte is consumed
//   cmd_rdy, cmd, data         last accepted packet, cmd_rdy until consumed
//   clr_cmd_rdy                host has consumed the packet
//   chk_err, pkt_timeout       1-clk pulses for dropped packets
//   resp, send_resp            response byte push
//   resp_full, resp_ovf        FIFO full / push-dropped pulse
//   tx_data, trmt, tx_done     UART transmitter handshake
//   resp_sent                  1-clk pulse per byte popped
module uart_cmd_pkt #(
  parameter int DATA_BYTES   = 2,
  parameter int CHK_EN       = 0,
  parameter int TIMEOUT_CLKS = 50000,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_rdy,
  output logic                    clr_rx_rdy,
  output logic                    cmd_rdy,
  output logic [7:0]              cmd,
  output logic [8*DATA_BYTES-1:0] data,
  input  logic                    clr_cmd_rdy,
  output logic                    chk_err,
  output logic                    pkt_timeout,
  input  logic [7:0]              resp,
  input  logic                    send_resp,
  output logic                    resp_full,
  output logic                    resp_ovf,
  output logic [7:0]              tx_data,
  output logic                    trmt,
  input  logic                    tx_done,
  output logic                    resp_sent
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TW = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam int AW = $clog2(RESP_DEPTH);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHK} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_WAIT}   tx_state_t;

  // ---------------------------------------------------------------- RX path
  rx_state_t       r_rx_state, w_rx_next;
  logic [7:0]      r_shadow_cmd;
  logic [DW-1:0]   r_shadow_data;
  logic [7:0]      r_chk_sum;
  logic [CW-1:0]   r_byte_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic            r_cmd_rdy, r_chk_err, r_pkt_timeout;
  logic [7:0]      r_cmd;
  logic [DW-1:0]   r_data;

  logic            w_last, w_to_hit, w_accept, w_bad_chk, w_expire;
  logic [7:0]      w_chk_total;
  logic [DW-1:0]   w_data_shift, w_accept_data;

  // Every state consumes a byte whenever one is offered.
  assign clr_rx_rdy  = rx_rdy;
  assign w_last      = (r_byte_cnt == CW'(DATA_BYTES - 1));
  assign w_chk_total = r_chk_sum + rx_data;
  assign w_to_hit    = (TIMEOUT_CLKS != 0) && (r_to_cnt == TW'(TIMEOUT_CLKS));

  generate
    if (DATA_BYTES > 1) begin : g_shift
      assign w_data_shift = {r_shadow_data[DW-9:0], rx_data};
    end else begin : g_single
      assign w_data_shift = rx_data;
    end
  endgenerate

  // Accepting from CHK uses the completed shadow; from PAYLOAD the final
  // payload byte is still on rx_data this cycle.
  assign w_accept_data = (r_rx_state == CHK) ? r_shadow_data : w_data_shift;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_rx_next = r_rx_state;
    w_accept  = 1'b0;
    w_bad_chk = 1'b0;
    w_expire  = 1'b0;
    case (r_rx_state)
      IDLE: if (rx_rdy) w_rx_next = PAYLOAD;
      PAYLOAD: begin
        if (rx_rdy) begin
          if (w_last) begin
            if (CHK_EN != 0) begin
              w_rx_next = CHK;
            end else begin
              w_rx_next = IDLE;
              w_accept  = 1'b1;
            end
          end
        end else if (w_to_hit) begin
          w_expire  = 1'b1;
          w_rx_next = IDLE;
        end
      end
      CHK: begin
        if (rx_rdy) begin
          w_rx_next = IDLE;
          if (w_chk_total == 8'h00) w_accept  = 1'b1;
          else                      w_bad_chk = 1'b1;
        end else if (w_to_hit) begin
          w_expire  = 1'b1;
          w_rx_next = IDLE;
        end
      end
      default: w_rx_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state    <= IDLE;
      r_shadow_cmd  <= '0;
      r_shadow_data <= '0;
      r_chk_sum     <= '0;
      r_byte_cnt    <= '0;
      r_to_cnt      <= '0;
      r_cmd_rdy     <= 1'b0;
      r_chk_err     <= 1'b0;
      r_pkt_timeout <= 1'b0;
      r_cmd         <= '0;
      r_data        <= '0;
    end else begin
      r_rx_state    <= w_rx_next;
      r_chk_err     <= w_bad_chk;
      r_pkt_timeout <= w_expire;

      // Inter-byte gap counter; saturates at the limit, a byte arriving in the
      // expiry cycle still wins because expiry requires !rx_rdy.
      if (rx_rdy || r_rx_state == IDLE)
        r_to_cnt <= '0;
      else if (TIMEOUT_CLKS != 0 && !w_to_hit)
        r_to_cnt <= r_to_cnt + 1'b1;

      if (rx_rdy && r_rx_state == IDLE) begin
        r_shadow_cmd <= rx_data;
        r_chk_sum    <= rx_data;
        r_byte_cnt   <= '0;
      end else if (rx_rdy && r_rx_state == PAYLOAD) begin
        r_shadow_data <= w_data_shift;
        r_chk_sum     <= w_chk_total;
        r_byte_cnt    <= r_byte_cnt + 1'b1;
      end

      // Acceptance has priority over any clear in the same cycle.
      if (w_accept)
        r_cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (rx_rdy && r_rx_state == IDLE))
        r_cmd_rdy <= 1'b0;

      if (w_accept) begin
        r_cmd  <= r_shadow_cmd;
        r_data <= w_accept_data;
      end
    end
  end

  assign cmd_rdy     = r_cmd_rdy;
  assign cmd         = r_cmd;
  assign data        = r_data;
  assign chk_err     = r_chk_err;
  assign pkt_timeout = r_pkt_timeout;

  // ---------------------------------------------------------------- TX path
  tx_state_t     r_tx_state, w_tx_next;
  logic [7:0]    r_mem [RESP_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          r_resp_ovf, r_resp_sent;
  logic          w_empty, w_full, w_push, w_pop, w_trmt;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = (r_tx_state == TX_WAIT) && tx_done;
  // When full, a simultaneous pop frees the slot being written.
  assign w_push  = send_resp && (!w_full || w_pop);

  always_comb begin
    w_tx_next = r_tx_state;
    w_trmt    = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (!w_empty) begin
        w_trmt    = 1'b1;
        w_tx_next = TX_WAIT;
      end
      TX_WAIT: if (tx_done) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // NOTE: the FIFO storage has no reset; the pointers alone define which
  // entries are valid, and tx_data is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= resp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state  <= TX_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_resp_ovf  <= 1'b0;
      r_resp_sent <= 1'b0;
    end else begin
      r_tx_state  <= w_tx_next;
      r_resp_ovf  <= send_resp && w_full && !w_pop;
      r_resp_sent <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign tx_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign trmt      = w_trmt;
  assign resp_full = w_full;
  assign resp_ovf  = r_resp_ovf;
  assign resp_sent = r_resp_sent;

endmodule

// File: tb/tb_uart_cmd_pkt.sv
// tb_uart_cmd_pkt
//   Self-checking bench for uart_cmd_pkt. Instance u_a runs without checksum
//   and a 100-clk timeout and carries the response FIFO traffic; instance u_b
//   runs with checksum enabled and the timeout disabled. Expected packets and
//   response bytes are queued when driven and compared when the DUT produces
//   them.
module tb_uart_cmd_pkt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A signals
  logic [7:0]  a_rx_data = 8'h00;
  logic        a_rx_rdy = 1'b0, a_clr_cmd_rdy = 1'b0, a_send_resp = 1'b0, a_tx_done = 1'b0;
  logic [7:0]  a_resp = 8'h00;
  logic        a_clr_rx_rdy, a_cmd_rdy, a_chk_err, a_pkt_timeout;
  logic        a_resp_full, a_resp_ovf, a_trmt, a_resp_sent;
  logic [7:0]  a_cmd, a_tx_data;
  logic [15:0] a_data;

  // instance B signals
  logic [7:0]  b_rx_data = 8'h00;
  logic        b_rx_rdy = 1'b0, b_clr_cmd_rdy = 1'b0, b_send_resp = 1'b0, b_tx_done = 1'b0;
  logic [7:0]  b_resp = 8'h00;
  logic        b_clr_rx_rdy, b_cmd_rdy, b_chk_err, b_pkt_timeout;
  logic        b_resp_full, b_resp_ovf, b_trmt, b_resp_sent;
  logic [7:0]  b_cmd, b_tx_data;
  logic [15:0] b_data;

  uart_cmd_pkt #(.DATA_BYTES(2), .CHK_EN(0), .TIMEOUT_CLKS(100), .RESP_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .rx_data(a_rx_data), .rx_rdy(a_rx_rdy), .clr_rx_rdy(a_clr_rx_rdy),
    .cmd_rdy(a_cmd_rdy), .cmd(a_cmd), .data(a_data), .clr_cmd_rdy(a_clr_cmd_rdy),
    .chk_err(a_chk_err), .pkt_timeout(a_pkt_timeout), .resp(a_resp), .send_resp(a_send_resp),
    .resp_full(a_resp_full), .resp_ovf(a_resp_ovf), .tx_data(a_tx_data), .trmt(a_trmt),
    .tx_done(a_tx_done), .resp_sent(a_resp_sent));

  uart_cmd_pkt #(.DATA_BYTES(2), .CHK_EN(1), .TIMEOUT_CLKS(0), .RESP_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .rx_data(b_rx_data), .rx_rdy(b_rx_rdy), .clr_rx_rdy(b_clr_rx_rdy),
    .cmd_rdy(b_cmd_rdy), .cmd(b_cmd), .data(b_data), .clr_cmd_rdy(b_clr_cmd_rdy),
    .chk_err(b_chk_err), .pkt_timeout(b_pkt_timeout), .resp(b_resp), .send_resp(b_send_resp),
    .resp_full(b_resp_full), .resp_ovf(b_resp_ovf), .tx_data(b_tx_data), .trmt(b_trmt),
    .tx_done(b_tx_done), .resp_sent(b_resp_sent));

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [23:0] rx_q[$];   // expected {cmd, data}
  logic [7:0]  tx_q[$];   // expected response bytes in order

  int   a_clr_cnt = 0;
  int   tx_sent_cnt = 0;
  int   resp_sent_cnt = 0;
  logic b_to_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte for exactly one clock; it is consumed on that edge.
  task automatic send(input bit sel_b, input logic [7:0] b);
    if (sel_b) begin b_rx_data = b; b_rx_rdy = 1'b1; end
    else       begin a_rx_data = b; a_rx_rdy = 1'b1; end
    tick();
    a_rx_rdy = 1'b0;
    b_rx_rdy = 1'b0;
  endtask

  always @(posedge clk) if (a_clr_rx_rdy) a_clr_cnt <= a_clr_cnt + 1;

  // TX scoreboard: every trmt must present the next queued byte.
  always @(negedge clk) begin
    if (a_trmt) begin
      check("tx_q_has_entry", 32'(tx_q.size() != 0), 32'd1);
      if (tx_q.size() != 0) check("tx_data_order", a_tx_data, tx_q.pop_front());
      tx_sent_cnt <= tx_sent_cnt + 1;
    end
    if (a_resp_sent)   resp_sent_cnt <= resp_sent_cnt + 1;
    if (b_pkt_timeout) b_to_seen <= 1'b1;
  end

  // UART transmitter model: tx_done 10 clocks after each trmt.
  initial begin
    forever begin
      @(negedge clk);
      if (a_trmt) begin
        repeat (10) @(posedge clk);
        #1 a_tx_done = 1'b1;
        @(posedge clk);
        #1 a_tx_done = 1'b0;
      end
    end
  end

  initial begin
    logic [23:0] exp_pkt;
    int c0, s0, r0, to_at;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_rdy",   a_cmd_rdy, 0);
    check("rst_cmd",       a_cmd, 0);
    check("rst_data",      a_data, 0);
    check("rst_timeout",   a_pkt_timeout, 0);
    check("rst_chk_err",   a_chk_err, 0);
    check("rst_trmt",      a_trmt, 0);
    check("rst_resp_sent", a_resp_sent, 0);
    check("rst_resp_ovf",  a_resp_ovf, 0);
    check("rst_resp_full", a_resp_full, 0);
    check("rst_tx_data",   a_tx_data, 0);
    check("rst_clr_rx",    a_clr_rx_rdy, 0);
    check("rst_b_cmd_rdy", b_cmd_rdy, 0);
    check("rst_b_chk_err", b_chk_err, 0);
    check("rst_b_fifo",    {b_trmt, b_resp_sent, b_resp_ovf, b_resp_full, b_tx_data}, 0);

    // Basic packet, no checksum
    tick();
    c0 = a_clr_cnt;
    rx_q.push_back({8'h05, 16'h1234});
    send(0, 8'h05); send(0, 8'h12); send(0, 8'h34);
    @(negedge clk);
    exp_pkt = rx_q.pop_front();
    check("basic_cmd_rdy", a_cmd_rdy, 1);
    check("basic_cmd",     a_cmd, exp_pkt[23:16]);
    check("basic_data",    a_data, exp_pkt[15:0]);
    check("basic_clr_cnt", a_clr_cnt - c0, 3);
    repeat (3) tick();
    @(negedge clk);
    check("cmd_rdy_hold", a_cmd_rdy, 1);
    tick();
    a_clr_cmd_rdy = 1'b1; tick(); a_clr_cmd_rdy = 1'b0;
    @(negedge clk);
    check("cmd_rdy_cleared", a_cmd_rdy, 0);

    // Partial packet then a long gap
    tick();
    send(0, 8'h05); send(0, 8'hAA);
    to_at = 0;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_pkt_timeout) begin to_at = k; break; end
    end
    check("timeout_clks", to_at, 101);
    @(negedge clk);
    check("timeout_pulse_1clk", a_pkt_timeout, 0);
    check("timeout_cmd_held",   a_cmd, 8'h05);
    check("timeout_data_held",  a_data, 16'h1234);
    check("timeout_no_cmd_rdy", a_cmd_rdy, 0);

    tick();
    rx_q.push_back({8'h07, 16'h0001});
    send(0, 8'h07); send(0, 8'h00); send(0, 8'h01);
    @(negedge clk);
    exp_pkt = rx_q.pop_front();
    check("resync_cmd_rdy", a_cmd_rdy, 1);
    check("resync_cmd",     a_cmd, exp_pkt[23:16]);
    check("resync_data",    a_data, exp_pkt[15:0]);

    // First byte of a new packet clears cmd_rdy; accept beats clr_cmd_rdy
    tick();
    send(0, 8'h09);
    @(negedge clk);
    check("cmd_rdy_clr_by_byte", a_cmd_rdy, 0);
    tick();
    send(0, 8'h11);
    rx_q.push_back({8'h09, 16'h1122});
    a_clr_cmd_rdy = 1'b1;
    send(0, 8'h22);
    a_clr_cmd_rdy = 1'b0;
    @(negedge clk);
    exp_pkt = rx_q.pop_front();
    check("set_wins_cmd_rdy", a_cmd_rdy, 1);
    check("set_wins_cmd",     a_cmd, exp_pkt[23:16]);
    check("set_wins_data",    a_data, exp_pkt[15:0]);
    tick();
    a_clr_cmd_rdy = 1'b1; tick(); a_clr_cmd_rdy = 1'b0;

    // Response FIFO: 5 back-to-back pushes into a depth-4 FIFO
    s0 = tx_sent_cnt;
    r0 = resp_sent_cnt;
    for (int k = 0; k < 4; k++) begin
      a_resp = 8'hA1 + 8'(k);
      a_send_resp = 1'b1;
      tx_q.push_back(a_resp);
      tick();
    end
    @(negedge clk);
    check("fifo_full", a_resp_full, 1);
    a_resp = 8'hA5;
    tick();
    a_send_resp = 1'b0;
    @(negedge clk);
    check("fifo_ovf_pulse", a_resp_ovf, 1);
    check("fifo_still_full", a_resp_full, 1);
    @(negedge clk);
    check("fifo_ovf_1clk", a_resp_ovf, 0);
    for (int k = 0; k < 400 && !((tx_sent_cnt - s0) == 4 && (resp_sent_cnt - r0) == 4); k++) tick();
    repeat (5) tick();
    @(negedge clk);
    check("fifo_bytes_sent", tx_sent_cnt - s0, 4);
    check("fifo_resp_sent",  resp_sent_cnt - r0, 4);
    check("fifo_q_drained",  tx_q.size(), 0);
    check("fifo_not_full",   a_resp_full, 0);

    // Checksum instance: gap with timeout disabled, then good checksum
    tick();
    send(1, 8'h02); send(1, 8'h10);
    repeat (200) tick();
    send(1, 8'h20);
    rx_q.push_back({8'h02, 16'h1020});
    send(1, 8'hCE);
    @(negedge clk);
    exp_pkt = rx_q.pop_front();
    check("chk_ok_cmd_rdy", b_cmd_rdy, 1);
    check("chk_ok_cmd",     b_cmd, exp_pkt[23:16]);
    check("chk_ok_data",    b_data, exp_pkt[15:0]);
    check("chk_ok_no_err",  b_chk_err, 0);
    check("chk_no_timeout", b_to_seen, 0);

    tick();
    send(1, 8'h02); send(1, 8'h10); send(1, 8'h20); send(1, 8'hCF);
    @(negedge clk);
    check("chk_bad_err",     b_chk_err, 1);
    check("chk_bad_cmd_rdy", b_cmd_rdy, 0);
    check("chk_bad_cmd",     b_cmd, 8'h02);
    check("chk_bad_data",    b_data, 16'h1020);
    @(negedge clk);
    check("chk_err_1clk",    b_chk_err, 0);

    // Reset mid-packet and mid-TX
    tick();
    a_resp = 8'hB1; a_send_resp = 1'b1; tx_q.push_back(a_resp); tick();
    a_resp = 8'hB2; tx_q.push_back(a_resp); tick();
    a_send_resp = 1'b0;
    send(0, 8'h05); send(0, 8'h12);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid_cmd_rdy", a_cmd_rdy, 0);
    check("rst_mid_cmd",     a_cmd, 0);
    check("rst_mid_data",    a_data, 0);
    check("rst_mid_fifo",    {a_trmt, a_resp_full, a_resp_ovf, a_resp_sent, a_tx_data}, 0);
    check("rst_mid_b_cmd",   {b_cmd_rdy, b_cmd, b_data}, 0);
    tick();
    rst = 1'b0;
    tx_q.delete();
    repeat (15) tick();
    @(negedge clk);
    check("post_rst_fifo_empty", {a_trmt, a_tx_data, a_resp_full}, 0);

    tick();
    rx_q.push_back({8'h33, 16'hBEEF});
    send(0, 8'h33); send(0, 8'hBE); send(0, 8'hEF);
    @(negedge clk);
    exp_pkt = rx_q.pop_front();
    check("post_rst_cmd_rdy", a_cmd_rdy, 1);
    check("post_rst_cmd",     a_cmd, exp_pkt[23:16]);
    check("post_rst_data",    a_data, exp_pkt[15:0]);

    tick();
    s0 = tx_sent_cnt;
    r0 = resp_sent_cnt;
    a_resp = 8'hC3; a_send_resp = 1'b1; tx_q.push_back(a_resp); tick();
    a_send_resp = 1'b0;
    for (int k = 0; k < 100 && (resp_sent_cnt - r0) != 1; k++) tick();
    @(negedge clk);
    check("post_rst_tx_sent",   tx_sent_cnt - s0, 1);
    check("post_rst_resp_sent", resp_sent_cnt - r0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
